// File: rtl/vend_sequencer.sv
// vend_sequencer: soda/diet vending controller.
// Owns customer credit (in nickels), arbitrates coin inputs, checks selections
// against PRICE, pulses a one-cycle dispense, then pays change one nickel at a
// time through a req/ack handshake with the change hopper.
// Optional feature: define VEND_CANCEL_EN to add a cancel input that refunds
// the whole credit as nickels without dispensing.
module vend_sequencer #(
  parameter int PRICE      = 9,
  parameter int MAX_CREDIT = 13
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       ni,
  input  logic       di,
  input  logic       qu,
  input  logic       soda,
  input  logic       diet,
  input  logic       change_ack,
`ifdef VEND_CANCEL_EN
  input  logic       cancel,
`endif
  output logic       giveSoda,
  output logic       giveDiet,
  output logic       change_req,
  output logic       coin_reject,
  output logic [3:0] credit,
  output logic       busy
);

  localparam logic [1:0] COLLECT    = 2'd0;
  localparam logic [1:0] VEND       = 2'd1;
  localparam logic [1:0] CHANGE_REQ = 2'd2;
  localparam logic [1:0] CHANGE_GAP = 2'd3;

  localparam logic [3:0] PRICE_N = 4'(PRICE);
  localparam logic [4:0] MAX_N   = 5'(MAX_CREDIT);

  // Highest-priority coin wins; lower coins in the same cycle are dropped.
  function automatic logic [2:0] coin_value(input logic q, input logic d, input logic n);
    if (q)      return 3'd5;
    else if (d) return 3'd2;
    else if (n) return 3'd1;
    else        return 3'd0;
  endfunction

  // Widened sum so a quarter on top of a high credit cannot wrap the check.
  function automatic logic coin_fits(input logic [3:0] cred, input logic [2:0] val);
    return ({1'b0, cred} + {2'b00, val}) <= MAX_N;
  endfunction

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] credit_nxt;
  logic       soda_nxt;
  logic       diet_nxt;
  logic       reject_nxt;
  logic       coin_any;
  logic [2:0] coin_val;
  logic       cancel_in;

`ifdef VEND_CANCEL_EN
  assign cancel_in = cancel;
`else
  assign cancel_in = 1'b0;
`endif

  assign coin_any = qu | di | ni;
  assign coin_val = coin_value(qu, di, ni);

  // Next-state, credit and pulse decisions for the coming cycle.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    soda_nxt   = 1'b0;
    diet_nxt   = 1'b0;
    reject_nxt = 1'b0;
    case (state)
      COLLECT: begin
        if (cancel_in && (credit != 4'd0)) begin
          // Refund everything as change; a simultaneous coin is refused.
          state_nxt  = CHANGE_REQ;
          reject_nxt = coin_any;
        end else if ((soda || diet) && (credit >= PRICE_N)) begin
          credit_nxt = credit - PRICE_N;
          state_nxt  = VEND;
          soda_nxt   = soda;
          diet_nxt   = ~soda;
          reject_nxt = coin_any;
        end else if (coin_any) begin
          if (coin_fits(credit, coin_val)) credit_nxt = credit + {1'b0, coin_val};
          else                             reject_nxt = 1'b1;
        end
      end
      VEND, CHANGE_GAP: begin
        reject_nxt = coin_any;
        state_nxt  = (credit != 4'd0) ? CHANGE_REQ : COLLECT;
      end
      CHANGE_REQ: begin
        reject_nxt = coin_any;
        if (change_ack) begin
          credit_nxt = credit - 4'd1;
          state_nxt  = CHANGE_GAP;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Register state, credit and every output; reset drops credit without payout.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= COLLECT;
      credit      <= 4'd0;
      giveSoda    <= 1'b0;
      giveDiet    <= 1'b0;
      change_req  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      giveSoda    <= soda_nxt;
      giveDiet    <= diet_nxt;
      change_req  <= (state_nxt == CHANGE_REQ);
      coin_reject <= reject_nxt;
      busy        <= (state_nxt != COLLECT);
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer. Each scenario drives a stimulus
// table one cycle at a time, pushes the hand-derived expected output word to
// a scoreboard queue, and pops/compares it once the registered outputs update.
// Build with +define+VEND_CANCEL_EN to exercise the cancel refund path.
module tb_vend_sequencer;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       ni = 1'b0, di = 1'b0, qu = 1'b0, soda = 1'b0, diet = 1'b0;
  logic       change_ack = 1'b0;
`ifdef VEND_CANCEL_EN
  logic       cancel = 1'b0;
`endif
  logic       giveSoda, giveDiet, change_req, coin_reject, busy;
  logic [3:0] credit;

  int tests  = 0;
  int failed = 0;
  logic [8:0] sb[$];

  // Stimulus word: {rst, cancel, ack, diet, soda, qu, di, ni}
  localparam logic [7:0] S_IDLE = 8'h00, S_NI = 8'h01, S_DI = 8'h02, S_QU = 8'h04;
  localparam logic [7:0] S_SODA = 8'h08, S_DIET = 8'h10, S_ACK = 8'h20;
  localparam logic [7:0] S_CAN  = 8'h40, S_RST = 8'h80;
  // Expected flags: {giveSoda, giveDiet, change_req, coin_reject, busy}
  localparam logic [4:0] E_0 = 5'b00000, E_GS = 5'b10000, E_GD = 5'b01000;
  localparam logic [4:0] E_CR = 5'b00100, E_RJ = 5'b00010, E_BZ = 5'b00001;

  vend_sequencer #(.PRICE(9), .MAX_CREDIT(13)) dut (
    .CLK(CLK), .rst(rst), .ni(ni), .di(di), .qu(qu), .soda(soda), .diet(diet),
    .change_ack(change_ack),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .giveSoda(giveSoda), .giveDiet(giveDiet), .change_req(change_req),
    .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

  function automatic logic [8:0] obs();
    return {giveSoda, giveDiet, change_req, coin_reject, busy, credit};
  endfunction

  task automatic apply(input logic [7:0] s);
    rst        = s[7];
`ifdef VEND_CANCEL_EN
    cancel     = s[6];
`endif
    change_ack = s[5];
    diet       = s[4];
    soda       = s[3];
    qu         = s[2];
    di         = s[1];
    ni         = s[0];
  endtask

  task automatic test_reset();
    logic [7:0] st [0:2] = '{S_RST | S_QU | S_SODA, S_RST, S_IDLE};
    logic [8:0] ex [0:2] = '{{E_0, 4'd0}, {E_0, 4'd0}, {E_0, 4'd0}};
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL reset step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_vend_exact();
    logic [7:0] st [0:6] = '{S_RST, S_QU, S_DI, S_DI, S_SODA, S_IDLE, S_IDLE};
    logic [8:0] ex [0:6] = '{{E_0, 4'd0}, {E_0, 4'd5}, {E_0, 4'd7}, {E_0, 4'd9},
                             {E_GS | E_BZ, 4'd0}, {E_0, 4'd0}, {E_0, 4'd0}};
    logic [8:0] e;
    for (int i = 0; i < 7; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL vend_exact step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_change_wait();
    logic [7:0] st [0:10] = '{S_RST, S_QU, S_QU, S_DIET, S_IDLE, S_IDLE, S_IDLE,
                              S_ACK, S_IDLE, S_ACK, S_NI};
    logic [8:0] ex [0:10] = '{{E_0, 4'd0}, {E_0, 4'd5}, {E_0, 4'd10}, {E_GD | E_BZ, 4'd1},
                              {E_CR | E_BZ, 4'd1}, {E_CR | E_BZ, 4'd1}, {E_CR | E_BZ, 4'd1},
                              {E_BZ, 4'd0}, {E_0, 4'd0}, {E_0, 4'd0}, {E_0, 4'd1}};
    logic [8:0] e;
    for (int i = 0; i < 11; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL change_wait step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] st [0:7] = '{S_RST, S_QU | S_DI | S_NI, S_SODA, S_DIET, S_DI, S_DI,
                             S_SODA | S_DIET, S_IDLE};
    logic [8:0] ex [0:7] = '{{E_0, 4'd0}, {E_0, 4'd5}, {E_0, 4'd5}, {E_0, 4'd5},
                             {E_0, 4'd7}, {E_0, 4'd9}, {E_GS | E_BZ, 4'd0}, {E_0, 4'd0}};
    logic [8:0] e;
    for (int i = 0; i < 8; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL priority step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] st [0:16] = '{S_RST, S_QU, S_QU, S_DI, S_DI, S_IDLE, S_NI, S_NI,
                              S_QU | S_DI, S_SODA, S_QU, S_QU, S_IDLE, S_SODA,
                              S_ACK, S_ACK, S_IDLE};
    logic [8:0] ex [0:16] = '{{E_0, 4'd0}, {E_0, 4'd5}, {E_0, 4'd10}, {E_0, 4'd12},
                              {E_RJ, 4'd12}, {E_0, 4'd12}, {E_0, 4'd13}, {E_RJ, 4'd13},
                              {E_RJ, 4'd13}, {E_GS | E_BZ, 4'd4},
                              {E_CR | E_RJ | E_BZ, 4'd4}, {E_CR | E_RJ | E_BZ, 4'd4},
                              {E_CR | E_BZ, 4'd4}, {E_CR | E_BZ, 4'd4},
                              {E_BZ, 4'd3}, {E_CR | E_BZ, 4'd3}, {E_CR | E_BZ, 4'd3}};
    logic [8:0] e;
    for (int i = 0; i < 17; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL overflow step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] st [0:11] = '{S_RST, S_QU, S_QU, S_DI, S_NI, S_SODA, S_IDLE, S_ACK,
                              S_IDLE, S_RST | S_ACK, S_IDLE, S_NI};
    logic [8:0] ex [0:11] = '{{E_0, 4'd0}, {E_0, 4'd5}, {E_0, 4'd10}, {E_0, 4'd12},
                              {E_0, 4'd13}, {E_GS | E_BZ, 4'd4}, {E_CR | E_BZ, 4'd4},
                              {E_BZ, 4'd3}, {E_CR | E_BZ, 4'd3}, {E_0, 4'd0},
                              {E_0, 4'd0}, {E_0, 4'd1}};
    logic [8:0] e;
    for (int i = 0; i < 12; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL reset_mid step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] st [0:12] = '{S_RST, S_QU, S_QU, S_SODA | S_NI, S_IDLE, S_ACK, S_QU,
                              S_QU, S_DI, S_DI, S_DIET, S_NI, S_NI};
    logic [8:0] ex [0:12] = '{{E_0, 4'd0}, {E_0, 4'd5}, {E_0, 4'd10},
                              {E_GS | E_RJ | E_BZ, 4'd1}, {E_CR | E_BZ, 4'd1},
                              {E_BZ, 4'd0}, {E_RJ, 4'd0}, {E_0, 4'd5}, {E_0, 4'd7},
                              {E_0, 4'd9}, {E_GD | E_BZ, 4'd0}, {E_RJ, 4'd0}, {E_0, 4'd1}};
    logic [8:0] e;
    for (int i = 0; i < 13; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL back_to_back step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask

`ifdef VEND_CANCEL_EN
  task automatic test_cancel();
    logic [7:0] st [0:18];
    logic [8:0] ex [0:18];
    logic [8:0] e;
    int n;
    st[0] = S_RST;                 ex[0] = {E_0, 4'd0};
    st[1] = S_CAN;                 ex[1] = {E_0, 4'd0};
    st[2] = S_QU;                  ex[2] = {E_0, 4'd5};
    st[3] = S_DI;                  ex[3] = {E_0, 4'd7};
    st[4] = S_CAN | S_SODA | S_NI; ex[4] = {E_CR | E_RJ | E_BZ, 4'd7};
    n = 5;
    for (int k = 7; k >= 1; k--) begin
      st[n] = S_ACK;  ex[n] = {E_BZ, 4'(k - 1)}; n++;
      st[n] = S_IDLE;
      ex[n] = (k > 1) ? {E_CR | E_BZ, 4'(k - 1)} : {E_0, 4'd0};
      n++;
    end
    for (int i = 0; i < 19; i++) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(posedge CLK); #1;
      e = sb.pop_front(); tests++;
      if (obs() !== e) begin
        failed++;
        $display("FAIL cancel step %0d: got %b want %b", i, obs(), e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vend_exact();
    test_change_wait();
    test_priority();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
`ifdef VEND_CANCEL_EN
    test_cancel();
`endif
    apply(S_IDLE);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
